m_pipereg_ctl: RTL and testbench

- Parametrised execute→memory pipeline register for the y86-64 pipelined core; replaces the plain always-load M register.
- Adds synchronous reset, stall (hold), bubble injection (NOP insert), a sticky exception kill, a valid flag and saturating stall/bubble event counters.
- Sits between the execute stage and the memory stage. Stall and bubble are driven by pipeline control logic.

---
 rtl/m_pipereg_ctl.sv | 135 +++++++++++++
 tb/tb_m_pipereg_ctl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/m_pipereg_ctl.sv
// Execute-to-memory pipeline register with stall, bubble injection, sticky
// exception kill, valid flag and saturating stall/bubble event counters.
module m_pipereg_ctl #(
  parameter int N       = 64,
  parameter int CNT_W   = 32,
  parameter int KILL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             m_stall,
  input  logic             m_bubble,
  input  logic             w_exc,
  input  logic [3:0]       e_icode,
  input  logic [3:0]       e_ifun,
  input  logic [3:0]       e_rA,
  input  logic [3:0]       e_rB,
  input  logic [3:0]       e_dstE,
  input  logic [3:0]       e_dstM,
  input  logic [2:0]       e_stat,
  input  logic             e_cnd,
  input  logic [N-1:0]     e_valA,
  input  logic [N-1:0]     e_valB,
  input  logic [N-1:0]     e_valC,
  input  logic [N-1:0]     e_valP,
  input  logic [N-1:0]     e_valE,
  output logic [3:0]       m_icode,
  output logic [3:0]       m_ifun,
  output logic [3:0]       m_rA,
  output logic [3:0]       m_rB,
  output logic [3:0]       m_dstE,
  output logic [3:0]       m_dstM,
  output logic [2:0]       m_stat,
  output logic             m_cnd,
  output logic [N-1:0]     m_valA,
  output logic [N-1:0]     m_valB,
  output logic [N-1:0]     m_valC,
  output logic [N-1:0]     m_valP,
  output logic [N-1:0]     m_valE,
  output logic             m_valid,
  output logic             m_killed,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] bubble_cnt
);

  typedef struct packed {
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [3:0]   rA;
    logic [3:0]   rB;
    logic [3:0]   dstE;
    logic [3:0]   dstM;
    logic [2:0]   stat;
    logic         cnd;
    logic [N-1:0] valA;
    logic [N-1:0] valB;
    logic [N-1:0] valC;
    logic [N-1:0] valP;
    logic [N-1:0] valE;
    logic         valid;
  } stage_t;

  localparam logic [2:0] STAT_AOK = 3'd1;

  stage_t           stage_q, stage_d, bub, load;
  logic             killed_q, killed_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    bub       = '0;
    bub.icode = 4'h1;
    bub.rA    = 4'hF;
    bub.rB    = 4'hF;
    bub.dstE  = 4'hF;
    bub.dstM  = 4'hF;
    bub.stat  = STAT_AOK;
  end

  always_comb begin
    load = '{icode: e_icode, ifun: e_ifun, rA: e_rA, rB: e_rB,
             dstE: e_dstE, dstM: e_dstM, stat: e_stat, cnd: e_cnd,
             valA: e_valA, valB: e_valB, valC: e_valC, valP: e_valP,
             valE: e_valE, valid: 1'b1};
  end

  // Stall outranks every bubble source, so a stall never touches the kill flag.
  always_comb begin
    stage_d      = stage_q;
    killed_d     = killed_q;
    stall_cnt_d  = stall_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (m_stall) begin
      if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else if (m_bubble || w_exc || killed_q) begin
      stage_d = bub;
      if (bubble_cnt_q != '1) bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
    end else begin
      stage_d = load;
      if ((KILL_EN != 0) && (e_stat != STAT_AOK)) killed_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q      <= bub;
      killed_q     <= 1'b0;
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stage_q      <= stage_d;
      killed_q     <= killed_d;
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign m_icode    = stage_q.icode;
  assign m_ifun     = stage_q.ifun;
  assign m_rA       = stage_q.rA;
  assign m_rB       = stage_q.rB;
  assign m_dstE     = stage_q.dstE;
  assign m_dstM     = stage_q.dstM;
  assign m_stat     = stage_q.stat;
  assign m_cnd      = stage_q.cnd;
  assign m_valA     = stage_q.valA;
  assign m_valB     = stage_q.valB;
  assign m_valC     = stage_q.valC;
  assign m_valP     = stage_q.valP;
  assign m_valE     = stage_q.valE;
  assign m_valid    = stage_q.valid;
  assign m_killed   = killed_q;
  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_m_pipereg_ctl.sv
// Scoreboard bench for m_pipereg_ctl: a default instance (kill enabled, 32-bit
// counters) and a second one with kill disabled and 4-bit counters.
module tb_m_pipereg_ctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, m_stall, m_bubble, w_exc;
  logic [3:0]  e_icode, e_ifun, e_rA, e_rB, e_dstE, e_dstM;
  logic [2:0]  e_stat;
  logic        e_cnd;
  logic [63:0] e_valA, e_valB, e_valC, e_valP, e_valE;

  logic [3:0]  a_icode, a_ifun, a_rA, a_rB, a_dstE, a_dstM;
  logic [2:0]  a_stat;
  logic        a_cnd, a_valid, a_killed;
  logic [63:0] a_valA, a_valB, a_valC, a_valP, a_valE;
  logic [31:0] a_scnt, a_bcnt;

  logic [3:0]  b_icode, b_ifun, b_rA, b_rB, b_dstE, b_dstM;
  logic [2:0]  b_stat;
  logic        b_cnd, b_valid, b_killed;
  logic [63:0] b_valA, b_valB, b_valC, b_valP, b_valE;
  logic [3:0]  b_scnt, b_bcnt;

  m_pipereg_ctl #(.N(64), .CNT_W(32), .KILL_EN(1)) u_dut (
    .clk(clk), .rst(rst), .m_stall(m_stall), .m_bubble(m_bubble), .w_exc(w_exc),
    .e_icode(e_icode), .e_ifun(e_ifun), .e_rA(e_rA), .e_rB(e_rB),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .e_stat(e_stat), .e_cnd(e_cnd),
    .e_valA(e_valA), .e_valB(e_valB), .e_valC(e_valC), .e_valP(e_valP), .e_valE(e_valE),
    .m_icode(a_icode), .m_ifun(a_ifun), .m_rA(a_rA), .m_rB(a_rB),
    .m_dstE(a_dstE), .m_dstM(a_dstM), .m_stat(a_stat), .m_cnd(a_cnd),
    .m_valA(a_valA), .m_valB(a_valB), .m_valC(a_valC), .m_valP(a_valP), .m_valE(a_valE),
    .m_valid(a_valid), .m_killed(a_killed), .stall_cnt(a_scnt), .bubble_cnt(a_bcnt)
  );

  m_pipereg_ctl #(.N(64), .CNT_W(4), .KILL_EN(0)) u_dut_nk (
    .clk(clk), .rst(rst), .m_stall(m_stall), .m_bubble(m_bubble), .w_exc(w_exc),
    .e_icode(e_icode), .e_ifun(e_ifun), .e_rA(e_rA), .e_rB(e_rB),
    .e_dstE(e_dstE), .e_dstM(e_dstM), .e_stat(e_stat), .e_cnd(e_cnd),
    .e_valA(e_valA), .e_valB(e_valB), .e_valC(e_valC), .e_valP(e_valP), .e_valE(e_valE),
    .m_icode(b_icode), .m_ifun(b_ifun), .m_rA(b_rA), .m_rB(b_rB),
    .m_dstE(b_dstE), .m_dstM(b_dstM), .m_stat(b_stat), .m_cnd(b_cnd),
    .m_valA(b_valA), .m_valB(b_valB), .m_valC(b_valC), .m_valP(b_valP), .m_valE(b_valE),
    .m_valid(b_valid), .m_killed(b_killed), .stall_cnt(b_scnt), .bubble_cnt(b_bcnt)
  );

  // bub=1 means the register-id/data fields are expected to hold bubble values,
  // otherwise the fixed pattern the stimulus always drives on them.
  typedef struct {
    logic        sel;
    logic        bub;
    logic [3:0]  icode;
    logic [2:0]  stat;
    logic [63:0] valE;
    logic        valid;
    logic        killed;
    logic [31:0] scnt;
    logic [31:0] bcnt;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  function automatic exp_t B(input logic sel, input logic k, input int s, input int b);
    exp_t e;
    e = '{sel: sel, bub: 1'b1, icode: 4'h1, stat: 3'd1, valE: 64'h0,
          valid: 1'b0, killed: k, scnt: 32'(s), bcnt: 32'(b)};
    return e;
  endfunction

  function automatic exp_t L(input logic sel, input logic [3:0] ic, input logic [2:0] sa,
                             input logic [63:0] ve, input logic k, input int s, input int b);
    exp_t e;
    e = '{sel: sel, bub: 1'b0, icode: ic, stat: sa, valE: ve,
          valid: 1'b1, killed: k, scnt: 32'(s), bcnt: 32'(b)};
    return e;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        if (!e.sel) begin
          chk("icode", 64'(a_icode), 64'(e.icode));
          chk("ifun", 64'(a_ifun), 64'h0);
          chk("rA", 64'(a_rA), e.bub ? 64'hF : 64'h3);
          chk("rB", 64'(a_rB), e.bub ? 64'hF : 64'h4);
          chk("dstE", 64'(a_dstE), e.bub ? 64'hF : 64'h5);
          chk("dstM", 64'(a_dstM), e.bub ? 64'hF : 64'h6);
          chk("stat", 64'(a_stat), 64'(e.stat));
          chk("cnd", 64'(a_cnd), e.bub ? 64'h0 : 64'h1);
          chk("valA", a_valA, e.bub ? 64'h0 : 64'h1111);
          chk("valB", a_valB, e.bub ? 64'h0 : 64'h2222);
          chk("valC", a_valC, e.bub ? 64'h0 : 64'h3333);
          chk("valP", a_valP, e.bub ? 64'h0 : 64'h4444);
          chk("valE", a_valE, e.valE);
          chk("valid", 64'(a_valid), 64'(e.valid));
          chk("killed", 64'(a_killed), 64'(e.killed));
          chk("stall_cnt", 64'(a_scnt), 64'(e.scnt));
          chk("bubble_cnt", 64'(a_bcnt), 64'(e.bcnt));
        end else begin
          chk("nk_icode", 64'(b_icode), 64'(e.icode));
          chk("nk_dstE", 64'(b_dstE), e.bub ? 64'hF : 64'h5);
          chk("nk_stat", 64'(b_stat), 64'(e.stat));
          chk("nk_valE", b_valE, e.valE);
          chk("nk_valA", b_valA, e.bub ? 64'h0 : 64'h1111);
          chk("nk_valid", 64'(b_valid), 64'(e.valid));
          chk("nk_killed", 64'(b_killed), 64'(e.killed));
          chk("nk_stall_cnt", 64'(b_scnt), 64'(e.scnt));
          chk("nk_bubble_cnt", 64'(b_bcnt), 64'(e.bcnt));
        end
      end
    end
  end

  task automatic step(input logic r, input logic st, input logic bu, input logic wx,
                      input logic [3:0] ic, input logic [2:0] sa, input logic [63:0] ve,
                      input exp_t e);
    rst = r; m_stall = st; m_bubble = bu; w_exc = wx;
    e_icode = ic; e_stat = sa; e_valE = ve;
    @(posedge clk);
    #1;
    sb.push_back(e);
    @(negedge clk);
  endtask

  initial begin : stim
    int wait_cyc;
    e_ifun = 4'h0; e_rA = 4'h3; e_rB = 4'h4; e_dstE = 4'h5; e_dstM = 4'h6;
    e_cnd = 1'b1;
    e_valA = 64'h1111; e_valB = 64'h2222; e_valC = 64'h3333; e_valP = 64'h4444;

    // Reset overrides arbitrary control and data inputs.
    step(1'b1, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 3'($urandom),
         {$urandom, $urandom}, B(0, 0, 0, 0));
    step(0, 0, 0, 0, 4'h6, 3'd1, 64'h15, L(0, 4'h6, 3'd1, 64'h15, 0, 0, 0));
    step(0, 0, 0, 0, 4'h6, 3'd1, 64'hAA, L(0, 4'h6, 3'd1, 64'hAA, 0, 0, 0));
    for (int i = 1; i <= 3; i++)
      step(0, 1, 0, 0, 4'h6, 3'd1, 64'hBB, L(0, 4'h6, 3'd1, 64'hAA, 0, i, 0));
    step(0, 0, 0, 0, 4'h6, 3'd1, 64'hBB, L(0, 4'h6, 3'd1, 64'hBB, 0, 3, 0));
    step(0, 0, 1, 0, 4'h6, 3'd1, 64'hCC, B(0, 0, 3, 1));
    step(0, 1, 1, 0, 4'h6, 3'd1, 64'hCC, B(0, 0, 4, 1));
    // Excepting instruction loads normally, then everything becomes bubbles.
    step(0, 0, 0, 0, 4'h5, 3'd3, 64'h77, L(0, 4'h5, 3'd3, 64'h77, 1, 4, 1));
    for (int i = 1; i <= 4; i++)
      step(0, 0, 0, 0, 4'h6, 3'd1, 64'h88, B(0, 1, 4, 1 + i));
    step(0, 1, 0, 0, 4'h6, 3'd1, 64'h88, B(0, 1, 5, 5));
    step(1, 1, 0, 0, 4'h6, 3'd1, 64'h88, B(0, 0, 0, 0));
    step(0, 0, 0, 0, 4'h2, 3'd1, 64'h99, L(0, 4'h2, 3'd1, 64'h99, 0, 0, 0));
    step(0, 0, 0, 1, 4'h2, 3'd1, 64'h9A, B(0, 0, 0, 1));
    step(0, 0, 0, 0, 4'h3, 3'd1, 64'h42, L(0, 4'h3, 3'd1, 64'h42, 0, 0, 1));

    // Kill-disabled, 4-bit counter instance.
    step(1, 0, 0, 0, 4'h6, 3'd1, 64'h0, B(1, 0, 0, 0));
    step(0, 0, 0, 0, 4'h7, 3'd4, 64'h5, L(1, 4'h7, 3'd4, 64'h5, 0, 0, 0));
    step(0, 0, 0, 0, 4'h6, 3'd1, 64'h6, L(1, 4'h6, 3'd1, 64'h6, 0, 0, 0));
    for (int i = 1; i <= 20; i++)
      step(0, 1, 0, 0, 4'h6, 3'd1, 64'h66, L(1, 4'h6, 3'd1, 64'h6, 0, (i > 15) ? 15 : i, 0));
    step(1, 0, 0, 0, 4'h6, 3'd1, 64'h66, B(1, 0, 0, 0));

    wait_cyc = 0;
    while (sb.size() > 0 && wait_cyc < 10) begin
      @(negedge clk);
      wait_cyc++;
    end
    @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
